// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the fetch-stage PC sequencer.
package pc_seq_pkg;

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } state_e;

  typedef enum logic [1:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_JMP,
    SRC_HOLD
  } pc_src_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

  function automatic logic [31:0] alignWord(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Priority select of the next fetch address and redirect-target alignment.
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] PC_STEP = PC_STEP_DEFAULT
) (
  input  logic [31:0] curPc_i,
  input  logic        active_i,
  input  logic        branchTaken_i,
  input  logic [31:0] branchTarget_i,
  input  logic        jumpValid_i,
  input  logic [31:0] jumpTarget_i,
  input  logic        holdReq_i,
  output logic [31:0] nextPc_o,
  output pc_src_e     src_o,
  output logic        misalign_o
);

  // Branch beats jump beats hold (halt or stall); an inactive fetch always holds.
  always_comb begin
    src_o      = SRC_HOLD;
    nextPc_o   = curPc_i;
    misalign_o = 1'b0;
    if (active_i) begin
      if (branchTaken_i) begin
        src_o      = SRC_BR;
        nextPc_o   = alignWord(branchTarget_i);
        misalign_o = |branchTarget_i[1:0];
      end else if (jumpValid_i) begin
        src_o      = SRC_JMP;
        nextPc_o   = alignWord(jumpTarget_i);
        misalign_o = |jumpTarget_i[1:0];
      end else if (!holdReq_i) begin
        src_o    = SRC_SEQ;
        nextPc_o = curPc_i + PC_STEP;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage controller: PC register, RUN/HALT FSM, stall watchdog and flush strobes.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP     = PC_STEP_DEFAULT,
  parameter int          STALL_LIMIT = 16,
  parameter int          CNT_W       = 5
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic        stall_req,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] currPC,
  output logic        fetch_valid,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        misalign_err,
  output logic        stall_timeout,
  output logic        halted
);

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               fetchValid_q, fetchValid_d;
  logic               misalign_q, misalign_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   stallCnt_q, stallCnt_d;

  logic [31:0]        selNextPc;
  pc_src_e            selSrc;
  logic               selMisalign;
  logic               active;
  logic               stallWin;

  // RUN with fetch_valid low only happens in the warm-up cycle after reset.
  assign active   = (state_q == ST_RUN) && fetchValid_q;
  assign stallWin = active && !branch_taken && !jump_valid && !halt_req && stall_req;

  pc_next_sel #(
    .PC_STEP(PC_STEP)
  ) u_next_sel (
    .curPc_i       (pc_q),
    .active_i      (active),
    .branchTaken_i (branch_taken),
    .branchTarget_i(branch_target),
    .jumpValid_i   (jump_valid),
    .jumpTarget_i  (jump_target),
    .holdReq_i     (halt_req || stall_req),
    .nextPc_o      (selNextPc),
    .src_o         (selSrc),
    .misalign_o    (selMisalign)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = selNextPc;
    fetchValid_d = fetchValid_q;
    misalign_d   = selMisalign;
    timeout_d    = timeout_q;
    stallCnt_d   = '0;
    case (state_q)
      ST_RUN: begin
        if (!fetchValid_q) begin
          fetchValid_d = 1'b1;
        end else if (selSrc == SRC_HOLD && halt_req) begin
          state_d      = ST_HALT;
          fetchValid_d = 1'b0;
        end else if (stallWin) begin
          stallCnt_d = (&stallCnt_q) ? stallCnt_q : stallCnt_q + CNT_W'(1);
          if (stallCnt_d == CNT_W'(STALL_LIMIT)) begin
            timeout_d = 1'b1;
          end
        end
      end
      ST_HALT: begin
        if (resume) begin
          state_d      = ST_RUN;
          fetchValid_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      fetchValid_q <= 1'b0;
      misalign_q   <= 1'b0;
      timeout_q    <= 1'b0;
      stallCnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetchValid_q <= fetchValid_d;
      misalign_q   <= misalign_d;
      timeout_q    <= timeout_d;
      stallCnt_q   <= stallCnt_d;
    end
  end

  assign currPC        = pc_q;
  assign fetch_valid   = fetchValid_q;
  assign misalign_err  = misalign_q;
  assign stall_timeout = timeout_q;
  assign halted        = (state_q == ST_HALT);
  assign flush_if_id   = !reset && active && (branch_taken || jump_valid);
  assign flush_id_ex   = !reset && active && branch_taken;

endmodule
